// File: rtl/scope_capture_pkg.sv
// Shared types for the scope capture block: FSM state encoding and the sample type
// used by the readout side.
package scope_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} scope_state_t;

  localparam int SCOPE_DATA_W = 12;

  typedef logic signed [SCOPE_DATA_W-1:0] sample_t;

endpackage

// File: rtl/scope_capture_ram.sv
// Simple dual-port capture buffer: one write port, one registered read port.
// Same-address read during write returns the old word.
module scope_ram #(
  parameter  int DATA_W = 12,
  parameter  int DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; only the read register clears.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) rdata <= '0;
    else          rdata <= mem[raddr];
  end

endmodule

// File: rtl/scope_capture.sv
// Triggered sample capture: waits for a rising crossing of TRIG_LEVEL, then stores DEPTH
// qualified samples. Define SCOPE_CAPTURE_AUTOTRIG_EN to force a trigger after AUTO_TIMEOUT samples.
module scope_capture
  import scope_pkg::*;
#(
  parameter  int                        DATA_W       = 12,
  parameter  int                        DEPTH        = 256,
  parameter  logic signed [DATA_W-1:0]  TRIG_LEVEL   = '0,
  parameter  int                        AUTO_TIMEOUT = 1024,
  localparam int                        ADDR_W       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] sample,
  input  logic              arm,
  output logic              busy,
  output logic              done,
  output logic              trig_forced,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  scope_state_t             state;
  logic [ADDR_W-1:0]        wr_ptr;
  logic signed [DATA_W-1:0] prev;
  logic                     prev_valid;
  logic signed [DATA_W-1:0] cur;
  logic                     crossing;
  logic                     timeout_hit;
  logic                     trigger;
  logic                     start_arm;
  logic                     we;
  logic [ADDR_W-1:0]        waddr;

  assign cur       = sample;
  assign start_arm = arm && (state == IDLE || state == DONE);

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    crossing = 1'b0;
    if (prev_valid && (prev < TRIG_LEVEL) && (cur >= TRIG_LEVEL)) crossing = 1'b1;
    trigger = crossing || timeout_hit;
    we      = sample_en && ((state == ARMED && trigger) || state == CAPTURE);
    waddr   = (state == CAPTURE) ? wr_ptr : '0;
  end

`ifdef SCOPE_CAPTURE_AUTOTRIG_EN
  localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;

  // to_cnt holds qualified samples already seen, so the current one is number to_cnt+1.
  assign timeout_hit = (state == ARMED) && sample_en && (to_cnt == TO_W'(AUTO_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      to_cnt      <= '0;
      trig_forced <= 1'b0;
    end else if (start_arm) begin
      to_cnt      <= '0;
      trig_forced <= 1'b0;
    end else if (state == ARMED && sample_en) begin
      to_cnt <= to_cnt + TO_W'(1);
      if (timeout_hit && !crossing) trig_forced <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign trig_forced = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_ptr     <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (arm) begin
            state      <= ARMED;
            busy       <= 1'b1;
            done       <= 1'b0;
            prev_valid <= 1'b0;
          end
        end
        ARMED: begin
          if (sample_en) begin
            prev       <= cur;
            prev_valid <= 1'b1;
            if (trigger) begin
              wr_ptr <= ADDR_W'(1);
              state  <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (sample_en) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (wr_ptr == ADDR_W'(DEPTH - 1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  scope_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we),
    .waddr   (waddr),
    .wdata   (sample),
    .raddr   (rd_addr),
    .rdata   (rd_data)
  );

endmodule
